ps2_host_transmitter: RTL and testbench

PS2_HOST_TRANSMITTER -- requirements
Module: ps2_host_transmitter

---
 rtl/ps2_host_transmitter_pkg.sv | 32 +++
 rtl/ps2_host_transmitter_clk_edge_detect.sv | 36 +++
 rtl/ps2_host_transmitter.sv | 163 ++++++++++++++++
 tb/tb_ps2_host_transmitter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_transmitter_pkg.sv
// Shared types and constants for the PS/2 host transmitter.
package PS2HostTxPkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BIT_CNT_W = 4;

  // Common host-to-device command bytes
  localparam logic [DATA_W-1:0] CMD_SET_LEDS = 8'hED;
  localparam logic [DATA_W-1:0] CMD_RESET    = 8'hFF;
  localparam logic [DATA_W-1:0] CMD_ENABLE   = 8'hF4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQUEST,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_FINISH
  } state_e;

  // Odd parity bit: makes the total count of ones (data + parity) odd
  function automatic logic odd_parity(input logic [DATA_W-1:0] d);
    return ~^d;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ps2_host_transmitter_clk_edge_detect.sv
// Two-flop synchronizers for the raw PS/2 lines plus a one-cycle
// falling-edge strobe on the synchronized clock. Shared with the receive side.
module ps2_clk_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_sync,
  output logic data_sync,
  output logic fall
);

  logic clk_meta;
  logic data_meta;
  logic clk_prev;

  // Synchronize both lines and register the 1->0 transition of the clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta  <= 1'b0;
      clk_sync  <= 1'b0;
      data_meta <= 1'b0;
      data_sync <= 1'b0;
      clk_prev  <= 1'b0;
      fall      <= 1'b0;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      data_meta <= ps2_data;
      data_sync <= data_meta;
      clk_prev  <= clk_sync;
      fall      <= clk_prev & ~clk_sync;
    end
  end

endmodule

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send,
// shift 8 data bits + odd parity + stop on device clock, then ACK check.
// Optional build macro PS2_TX_ACK_CHECK_EN: when defined a missing device
// ACK flags txError; otherwise the ACK edge is consumed and data ignored.
import PS2HostTxPkg::*;

module ps2_host_transmitter #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] txData,
  input  logic              txStart,
  output logic              txBusy,
  output logic              txDone,
  output logic              txError,
  input  logic              ps2ClkIn,
  input  logic              ps2DataIn,
  output logic              ps2ClkOe,
  output logic              ps2DataOe
);

  localparam int unsigned INH_W = cnt_width(INHIBIT_CYCLES);
  localparam int unsigned TO_W  = cnt_width(TIMEOUT_CYCLES);

  state_e               state, state_n;
  logic [DATA_W-1:0]    data_q, data_n;
  logic                 parity_q, parity_n;
  logic [INH_W-1:0]     inh_cnt, inh_n;
  logic [TO_W-1:0]      to_cnt, to_n;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_n;
  logic                 err_q, err_n;
  logic                 shift_oe;
  logic                 clk_oe_n, data_oe_n, busy_n, done_n, error_n;

  logic clk_sync;
  logic data_sync;
  logic fall;

  ps2_clk_edge_detect u_edge (
    .clk       (clk),
    .rst_n     (rst),
    .ps2_clk   (ps2ClkIn),
    .ps2_data  (ps2DataIn),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .fall      (fall)
  );

  // State, datapath and registered line/handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      data_q    <= '0;
      parity_q  <= 1'b0;
      inh_cnt   <= '0;
      to_cnt    <= '0;
      bit_cnt   <= '0;
      err_q     <= 1'b0;
      ps2ClkOe  <= 1'b0;
      ps2DataOe <= 1'b0;
      txBusy    <= 1'b0;
      txDone    <= 1'b0;
      txError   <= 1'b0;
    end else begin
      state     <= state_n;
      data_q    <= data_n;
      parity_q  <= parity_n;
      inh_cnt   <= inh_n;
      to_cnt    <= to_n;
      bit_cnt   <= bit_n;
      err_q     <= err_n;
      ps2ClkOe  <= clk_oe_n;
      ps2DataOe <= data_oe_n;
      txBusy    <= busy_n;
      txDone    <= done_n;
      txError   <= error_n;
    end
  end

  // Next-state, counters and next output values (outputs follow state_n)
  always_comb begin
    state_n  = state;
    data_n   = data_q;
    parity_n = parity_q;
    inh_n    = inh_cnt;
    to_n     = to_cnt;
    bit_n    = bit_cnt;
    err_n    = err_q;
    shift_oe = ps2DataOe;

    case (state)
      ST_IDLE: begin
        if (txStart) begin
          state_n  = ST_INHIBIT;
          data_n   = txData;
          parity_n = odd_parity(txData);
          inh_n    = '0;
          to_n     = '0;
          bit_n    = '0;
          err_n    = 1'b0;
        end
      end
      ST_INHIBIT: begin
        if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) state_n = ST_REQUEST;
        else                                       inh_n   = inh_cnt + INH_W'(1);
      end
      ST_REQUEST: begin
        // Timeout counter measures cycles elapsed since the REQUEST cycle
        state_n = ST_SHIFT;
        to_n    = TO_W'(1);
      end
      ST_SHIFT: begin
        if (fall) begin
          bit_n = bit_cnt + BIT_CNT_W'(1);
          if (bit_cnt < BIT_CNT_W'(8))       shift_oe = ~data_q[bit_cnt[2:0]];
          else if (bit_cnt == BIT_CNT_W'(8)) shift_oe = ~parity_q;
          else                               state_n  = ST_ACK;
        end
      end
      ST_ACK: begin
        if (fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
          if (data_sync) err_n = 1'b1;
`endif
          state_n = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_sync && data_sync) state_n = ST_FINISH;
      end
      ST_FINISH: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // Frame timeout overrides any other progress once the device stalls
    if (state == ST_SHIFT || state == ST_ACK || state == ST_WAIT_IDLE) begin
      if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        state_n = ST_FINISH;
        err_n   = 1'b1;
      end else begin
        to_n = to_cnt + TO_W'(1);
      end
    end

    clk_oe_n = (state_n == ST_INHIBIT) || (state_n == ST_REQUEST);
    busy_n   = (state_n != ST_IDLE);
    done_n   = (state_n == ST_FINISH);
    error_n  = (state_n == ST_FINISH) && err_n;

    case (state_n)
      ST_REQUEST: data_oe_n = 1'b1;
      ST_SHIFT:   data_oe_n = shift_oe;
      default:    data_oe_n = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Self-checking bench for ps2_host_transmitter with a PS/2 device model.
// Expected ACK error behaviour follows build macro PS2_TX_ACK_CHECK_EN.
`timescale 1ns/1ps
module tb_ps2_host_transmitter;
  import PS2HostTxPkg::*;

  localparam int unsigned INH  = 10;
  localparam int unsigned TO_A = 1000;
  localparam int unsigned TO_B = 100;
`ifdef PS2_TX_ACK_CHECK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data_a, tx_data_b;
  logic       tx_start_a, tx_start_b;
  logic       busy_a, done_a, err_a, clk_oe_a, data_oe_a;
  logic       busy_b, done_b, err_b, clk_oe_b, data_oe_b;
  logic       ps2_clk_a, ps2_data_a, ps2_clk_b, ps2_data_b;
  logic       dev_clk, dev_data;

  // Open-drain lines: host pull-down wins over device release
  assign ps2_clk_a  = ~clk_oe_a & dev_clk;
  assign ps2_data_a = ~data_oe_a & dev_data;
  // Second instance sees a device that never clocks
  assign ps2_clk_b  = ~clk_oe_b;
  assign ps2_data_b = ~data_oe_b;

  always #5 clk = ~clk;

  ps2_host_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO_A)) dut (
    .clk(clk), .rst(rst), .txData(tx_data_a), .txStart(tx_start_a),
    .txBusy(busy_a), .txDone(done_a), .txError(err_a),
    .ps2ClkIn(ps2_clk_a), .ps2DataIn(ps2_data_a),
    .ps2ClkOe(clk_oe_a), .ps2DataOe(data_oe_a)
  );

  ps2_host_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO_B)) dut_to (
    .clk(clk), .rst(rst), .txData(tx_data_b), .txStart(tx_start_b),
    .txBusy(busy_b), .txDone(done_b), .txError(err_b),
    .ps2ClkIn(ps2_clk_b), .ps2DataIn(ps2_data_b),
    .ps2ClkOe(clk_oe_b), .ps2DataOe(data_oe_b)
  );

  int checks = 0;
  int passed = 0;
  int done_cnt_a = 0;

  // Count every done pulse of the main instance
  always begin
    @(posedge clk);
    #1;
    if (done_a) done_cnt_a++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One host frame against the device model; abort_edge>0 resets mid-frame
  task automatic run_frame(input logic [7:0] d, input bit give_ack, input int abort_edge);
    logic [10:0] seen, exp_frame;
    logic        exp_par;
    int          n, first_doe, lo, hi, k, done_before;
    exp_par     = ($countones(d) % 2 == 0);
    exp_frame   = {1'b1, exp_par, d, 1'b0};
    done_before = done_cnt_a;
    seen        = '0;

    @(negedge clk);
    tx_data_a  = d;
    tx_start_a = 1'b1;
    @(negedge clk);
    tx_start_a = 1'b0;
    tx_data_a  = ~d;
    check_eq("busy_after_start", 32'(busy_a), 32'd1);

    n = 0;
    first_doe = 0;
    while (clk_oe_a && n < int'(INH) + 20) begin
      n++;
      if (data_oe_a && first_doe == 0) first_doe = n;
      if (n == 3) begin
        tx_start_a = 1'b1;
        tx_data_a  = 8'h5A ^ d;
      end else begin
        tx_start_a = 1'b0;
      end
      @(negedge clk);
    end
    tx_start_a = 1'b0;
    check_eq("clk_low_cycles", 32'(n), 32'(INH + 1));
    check_eq("start_bit_cycle", 32'(first_doe), 32'(INH + 1));
    check_eq("start_bit_held", 32'(data_oe_a), 32'd1);

    repeat ($urandom_range(1, 4)) @(negedge clk);
    for (int e = 0; e < 11; e++) begin
      seen[e] = ps2_data_a;
      if (e == 10 && give_ack) dev_data = 1'b0;
      lo = $urandom_range(6, 9);
      hi = (e == 10) ? 0 : $urandom_range(3, 6);
      dev_clk = 1'b0;
      repeat (lo) @(negedge clk);
      if (e + 1 == abort_edge) begin
        rst = 1'b0;
        #1;
        check_eq("abort_clk_oe", 32'(clk_oe_a), 32'd0);
        check_eq("abort_data_oe", 32'(data_oe_a), 32'd0);
        check_eq("abort_busy", 32'(busy_a), 32'd0);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("abort_no_done", 32'(done_cnt_a - done_before), 32'd0);
        return;
      end
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      repeat (hi) @(negedge clk);
    end
    check_eq($sformatf("frame_%02h", d), 32'(seen), 32'(exp_frame));

    k = 0;
    while (!done_a && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq("done_seen", 32'(done_a), 32'd1);
    check_eq($sformatf("tx_error_%02h_ack%0d", d, give_ack), 32'(err_a), 32'(!give_ack && ACK_EN));
    check_eq("lines_released", 32'({clk_oe_a, data_oe_a}), 32'd0);
    @(negedge clk);
    check_eq("done_one_cycle", 32'(done_a), 32'd0);
    check_eq("busy_cleared", 32'(busy_a), 32'd0);
    check_eq("done_count", 32'(done_cnt_a - done_before), 32'd1);
  endtask

  initial begin
    int n, k;
    rst        = 1'b0;
    tx_data_a  = '0;
    tx_data_b  = '0;
    tx_start_a = 1'b0;
    tx_start_b = 1'b0;
    dev_clk    = 1'b1;
    dev_data   = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs_a", 32'({busy_a, done_a, err_a, clk_oe_a, data_oe_a}), 32'd0);
    check_eq("reset_outputs_b", 32'({busy_b, done_b, err_b, clk_oe_b, data_oe_b}), 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    run_frame(CMD_SET_LEDS, 1'b1, 0);
    run_frame(8'h01, 1'b1, 0);
    run_frame(CMD_RESET, 1'b1, 0);
    run_frame(8'h00, 1'b1, 0);
    run_frame(CMD_ENABLE, 1'b0, 0);
    for (int i = 0; i < 6; i++)
      run_frame(8'($urandom), ($urandom_range(0, 3) != 0), 0);
    run_frame(8'hA5, 1'b1, 4);
    run_frame(CMD_SET_LEDS, 1'b1, 0);

    // Device never clocks: frame must time out exactly TO_B cycles after REQUEST
    @(negedge clk);
    tx_data_b  = 8'($urandom);
    tx_start_b = 1'b1;
    @(negedge clk);
    tx_start_b = 1'b0;
    n = 0;
    while (!(clk_oe_b && data_oe_b) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("to_request_seen", 32'(clk_oe_b & data_oe_b), 32'd1);
    k = 0;
    while (!done_b && k < int'(TO_B) + 20) begin
      @(negedge clk);
      k++;
      if (k == int'(TO_B) - 1) check_eq("to_start_held", 32'(data_oe_b), 32'd1);
    end
    check_eq("to_done_cycle", 32'(k), 32'(TO_B));
    check_eq("to_error", 32'(err_b), 32'd1);
    check_eq("to_lines_released", 32'({clk_oe_b, data_oe_b}), 32'd0);
    @(negedge clk);
    check_eq("to_busy_cleared", 32'(busy_b), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
